// File: rtl/memory_access_cycle_pkg.sv
// Shared definitions for the memory stage: FSM encoding and error-data default.
package memory_access_cycle_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } state_t;

   // Written to ReadDataW when a load is abandoned after the timeout.
   localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

endpackage

// File: rtl/memory_access_cycle_mem_wb.sv
// MEM/WB pipeline register; a stalled M stage turns into a writeback bubble.
module mem_wb_register (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_stall,
   input  logic        i_reg_write,
   input  logic        i_result_src,
   input  logic [4:0]  i_rd,
   input  logic [31:0] i_pc4,
   input  logic [31:0] i_alu,
   input  logic        i_rdata_we,
   input  logic [31:0] i_rdata,
   output logic        o_reg_write,
   output logic        o_result_src,
   output logic [4:0]  o_rd,
   output logic [31:0] o_pc4,
   output logic [31:0] o_alu,
   output logic [31:0] o_rdata
);

   // Capture M-stage fields when the stage advances, bubble the controls otherwise.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_reg_write  <= 1'b0;
         o_result_src <= 1'b0;
         o_rd         <= '0;
         o_pc4        <= '0;
         o_alu        <= '0;
         o_rdata      <= '0;
      end else begin
         if (i_stall) begin
            o_reg_write  <= 1'b0;
            o_result_src <= 1'b0;
         end else begin
            o_reg_write  <= i_reg_write;
            o_result_src <= i_result_src;
            o_rd         <= i_rd;
            o_pc4        <= i_pc4;
            o_alu        <= i_alu;
         end
         // Load data only moves on a completed (or abandoned) load.
         if (i_rdata_we) o_rdata <= i_rdata;
      end
   end

endmodule

// File: rtl/memory_access_cycle.sv
// Memory stage: turns loads/stores into dmem valid/ready transactions, stalls
// the pipeline while an access is outstanding, and owns the MEM/WB register.
module memory_access_cycle
   import memory_access_cycle_pkg::*;
#(
   parameter int          TIMEOUT  = 0,
   parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        RegWriteM,
   input  logic        MemWriteM,
   input  logic        ResultSrcM,
   input  logic [4:0]  RD_M,
   input  logic [31:0] PCPlus4M,
   input  logic [31:0] WriteDataM,
   input  logic [31:0] ALU_ResultM,
   output logic        dmem_req_valid,
   input  logic        dmem_req_ready,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_rsp_valid,
   input  logic [31:0] dmem_rdata,
   output logic        StallM,
   output logic        dmem_err,
   output logic        RegWriteW,
   output logic        ResultSrcW,
   output logic [4:0]  RD_W,
   output logic [31:0] PCPlus4W,
   output logic [31:0] ALU_ResultW,
   output logic [31:0] ReadDataW
);

   localparam int          CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam bit          TO_EN  = (TIMEOUT > 0);
   localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

   state_t        r_state;
   logic [CW-1:0] r_wait_cnt;
   logic          r_err;

   logic          w_access;
   logic          w_in_wait;
   logic          w_hs;
   logic          w_store_done;
   logic          w_rsp_done;
   logic          w_timeout;
   logic          w_complete;
   logic          w_rdata_we;
   logic [31:0]   w_rdata;

   assign w_access  = MemWriteM | ResultSrcM;
   assign w_in_wait = (r_state == WAIT);

   // Request is presented straight from the M-stage inputs; upstream holds them
   // stable while stalled, so the payload cannot change during REQ.
   assign dmem_req_valid = w_access & ~w_in_wait;
   assign dmem_we        = MemWriteM;
   assign dmem_addr      = ALU_ResultM;
   assign dmem_wdata     = WriteDataM;

   assign w_hs         = dmem_req_valid & dmem_req_ready;
   assign w_store_done = w_hs & MemWriteM;
   // Responses only count in WAIT, so a load always stalls at least one cycle.
   assign w_rsp_done   = w_in_wait & dmem_rsp_valid;
   assign w_timeout    = TO_EN & w_in_wait & ~dmem_rsp_valid & (r_wait_cnt == TO_VAL);
   assign w_complete   = w_store_done | w_rsp_done | w_timeout;

   assign StallM   = w_access & ~w_complete;
   assign dmem_err = r_err;

   assign w_rdata_we = w_rsp_done | w_timeout;
   assign w_rdata    = w_rsp_done ? dmem_rdata : ERR_DATA;

   // Access FSM with WAIT-cycle counter and sticky timeout flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_wait_cnt <= '0;
         r_err      <= 1'b0;
      end else begin
         case (r_state)
            IDLE, REQ: begin
               if (w_hs) begin
                  if (MemWriteM) begin
                     r_state <= IDLE;
                  end else begin
                     r_state    <= WAIT;
                     r_wait_cnt <= '0;
                  end
               end else if (w_access) begin
                  r_state <= REQ;
               end else begin
                  r_state <= IDLE;
               end
            end
            WAIT: begin
               if (w_rsp_done) begin
                  r_state <= IDLE;
               end else if (w_timeout) begin
                  r_state <= IDLE;
                  r_err   <= 1'b1;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   mem_wb_register u_mem_wb (
      .i_clk        (clk),
      .i_rst_n      (rst),
      .i_stall      (StallM),
      .i_reg_write  (RegWriteM),
      .i_result_src (ResultSrcM),
      .i_rd         (RD_M),
      .i_pc4        (PCPlus4M),
      .i_alu        (ALU_ResultM),
      .i_rdata_we   (w_rdata_we),
      .i_rdata      (w_rdata),
      .o_reg_write  (RegWriteW),
      .o_result_src (ResultSrcW),
      .o_rd         (RD_W),
      .o_pc4        (PCPlus4W),
      .o_alu        (ALU_ResultW),
      .o_rdata      (ReadDataW)
   );

endmodule

// File: tb/tb_memory_access_cycle.sv
// Scoreboard bench for the memory stage: expected MEM/WB contents are queued
// when an instruction is issued and compared once it leaves the stage.
module tb_memory_access_cycle;

   typedef struct packed {
      logic        rw;
      logic        rs;
      logic [4:0]  rd;
      logic [31:0] pc;
      logic [31:0] alu;
      logic [31:0] rdat;
   } wb_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        RegWriteM, MemWriteM, ResultSrcM;
   logic [4:0]  RD_M;
   logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;
   logic        dmem_req_valid, dmem_req_ready, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic        dmem_rsp_valid;
   logic [31:0] dmem_rdata;
   logic        StallM, dmem_err;
   logic        RegWriteW, ResultSrcW;
   logic [4:0]  RD_W;
   logic [31:0] PCPlus4W, ALU_ResultW, ReadDataW;

   int          n_cmp = 0;
   int          n_bad = 0;
   wb_t         sb_q[$];
   logic [31:0] last_rdata = 32'h0;

   memory_access_cycle #(.TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
      .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM),
      .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
      .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata),
      .StallM(StallM), .dmem_err(dmem_err),
      .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RD_W(RD_W),
      .PCPlus4W(PCPlus4W), .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic wb_t got_wb();
      return {RegWriteW, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW, ReadDataW};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_nop();
      RegWriteM = 0; MemWriteM = 0; ResultSrcM = 0; RD_M = '0;
      PCPlus4M = '0; WriteDataM = '0; ALU_ResultM = '0;
      dmem_req_ready = 0; dmem_rsp_valid = 0;
   endtask

   // Drives one M-stage instruction until it leaves the stage (bounded).
   // Spurious responses are pulsed before the handshake; they must be ignored.
   task automatic do_op(input logic we, input logic ld, input logic rw, input logic [4:0] rd,
                        input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] wd,
                        input int ready_lo, input int rsp_after, input bit rsp_en,
                        output int stalls, output bit pay_bad, output bit bub_bad,
                        output logic v0, output logic we0);
      bit done;
      MemWriteM = we; ResultSrcM = ld; RegWriteM = rw; RD_M = rd;
      PCPlus4M = pc; ALU_ResultM = alu; WriteDataM = wd;
      stalls = 0; pay_bad = 0; bub_bad = 0; v0 = 0; we0 = 0; done = 0;
      for (int c = 0; c < 20 && !done; c++) begin
         dmem_req_ready = (c >= ready_lo);
         dmem_rsp_valid = rsp_en && ((c == ready_lo + rsp_after) || (c < ready_lo));
         if (c > 0 && (RegWriteW !== 1'b0 || ResultSrcW !== 1'b0)) bub_bad = 1;
         @(negedge clk);
         if (c == 0) begin v0 = dmem_req_valid; we0 = dmem_we; end
         if (dmem_req_valid === 1'b1 &&
             (dmem_addr !== alu || dmem_we !== we || dmem_wdata !== wd)) pay_bad = 1;
         if (StallM === 1'b0) done = 1;
         else stalls++;
         tick();
      end
      if (!done) stalls = -1;
      set_nop();
   endtask

   task automatic test_reset();
      set_nop();
      dmem_rdata = '0;
      rst = 0;
      #12;
      n_cmp++; if (got_wb() !== wb_t'(0)) begin n_bad++; $display("FAIL reset_wb: got %h exp 0", got_wb()); end
      n_cmp++; if (dmem_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b exp 0", dmem_err); end
      n_cmp++; if (dmem_req_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b exp 0", dmem_req_valid); end
      n_cmp++; if (StallM !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b exp 0", StallM); end
      @(negedge clk);
      rst = 1;
      tick();
   endtask

   task automatic test_alu();
      int st; bit pb, bb; logic v0, we0; wb_t e, g;
      sb_q.push_back({1'b1, 1'b0, 5'd5, 32'h1004, 32'h2A, last_rdata});
      do_op(0, 0, 1, 5'd5, 32'h1004, 32'h2A, 32'h0, 0, 0, 0, st, pb, bb, v0, we0);
      n_cmp++; if (st !== 0) begin n_bad++; $display("FAIL alu_stall: got %0d exp 0", st); end
      e = sb_q.pop_front(); g = got_wb();
      n_cmp++; if (g !== e) begin n_bad++; $display("FAIL alu_wb: got %h exp %h", g, e); end
   endtask

   task automatic test_store();
      int st; bit pb, bb; logic v0, we0; wb_t e, g;
      sb_q.push_back({1'b0, 1'b0, 5'd0, 32'h1008, 32'h100, last_rdata});
      do_op(1, 0, 0, 5'd0, 32'h1008, 32'h100, 32'h55AA, 0, 0, 0, st, pb, bb, v0, we0);
      n_cmp++; if (v0 !== 1'b1 || we0 !== 1'b1) begin n_bad++; $display("FAIL store_req: got v=%b we=%b exp v=1 we=1", v0, we0); end
      n_cmp++; if (st !== 0) begin n_bad++; $display("FAIL store_stall: got %0d exp 0", st); end
      n_cmp++; if (pb !== 1'b0) begin n_bad++; $display("FAIL store_payload: got bad=%b exp 0", pb); end
      e = sb_q.pop_front(); g = got_wb();
      n_cmp++; if (g !== e) begin n_bad++; $display("FAIL store_wb: got %h exp %h", g, e); end
   endtask

   task automatic test_load();
      int st; bit pb, bb; logic v0, we0; wb_t e, g;
      dmem_rdata = 32'hCAFEF00D;
      last_rdata = 32'hCAFEF00D;
      sb_q.push_back({1'b1, 1'b1, 5'd7, 32'h100C, 32'h200, last_rdata});
      do_op(0, 1, 1, 5'd7, 32'h100C, 32'h200, 32'h0, 2, 3, 1, st, pb, bb, v0, we0);
      n_cmp++; if (st !== 5) begin n_bad++; $display("FAIL load_stall: got %0d exp 5", st); end
      n_cmp++; if (pb !== 1'b0) begin n_bad++; $display("FAIL load_payload: got bad=%b exp 0", pb); end
      n_cmp++; if (bb !== 1'b0) begin n_bad++; $display("FAIL load_bubble: got bad=%b exp 0", bb); end
      e = sb_q.pop_front(); g = got_wb();
      n_cmp++; if (g !== e) begin n_bad++; $display("FAIL load_wb: got %h exp %h", g, e); end
   endtask

   task automatic test_timeout();
      int st; bit pb, bb; logic v0, we0; wb_t e, g;
      dmem_rdata = 32'h12345678;
      last_rdata = 32'hDEADBEEF;
      sb_q.push_back({1'b1, 1'b1, 5'd9, 32'h1010, 32'h300, last_rdata});
      do_op(0, 1, 1, 5'd9, 32'h1010, 32'h300, 32'h0, 0, 0, 0, st, pb, bb, v0, we0);
      n_cmp++; if (st !== 5) begin n_bad++; $display("FAIL to_stall: got %0d exp 5", st); end
      n_cmp++; if (bb !== 1'b0) begin n_bad++; $display("FAIL to_bubble: got bad=%b exp 0", bb); end
      e = sb_q.pop_front(); g = got_wb();
      n_cmp++; if (g !== e) begin n_bad++; $display("FAIL to_wb: got %h exp %h", g, e); end
      n_cmp++; if (dmem_err !== 1'b1) begin n_bad++; $display("FAIL to_err: got %b exp 1", dmem_err); end
      // A late response with nothing outstanding must not touch ReadDataW.
      dmem_rsp_valid = 1;
      dmem_rdata = 32'h11111111;
      @(negedge clk);
      n_cmp++; if (StallM !== 1'b0) begin n_bad++; $display("FAIL late_stall: got %b exp 0", StallM); end
      tick();
      dmem_rsp_valid = 0;
      n_cmp++; if (ReadDataW !== last_rdata || dmem_err !== 1'b1) begin
         n_bad++; $display("FAIL late_rsp: got rdata=%h err=%b exp rdata=%h err=1", ReadDataW, dmem_err, last_rdata);
      end
   endtask

   task automatic test_reset_mid();
      wb_t g;
      dmem_rdata = 32'h0BADF00D;
      MemWriteM = 0; ResultSrcM = 1; RegWriteM = 1; RD_M = 5'd4;
      PCPlus4M = 32'h1018; ALU_ResultM = 32'h500; dmem_req_ready = 1;
      tick();
      dmem_req_ready = 0;
      #1;
      n_cmp++; if (StallM !== 1'b1) begin n_bad++; $display("FAIL rmid_wait: got %b exp 1", StallM); end
      rst = 0;
      #1;
      g = got_wb();
      n_cmp++; if (g !== wb_t'(0) || dmem_err !== 1'b0) begin
         n_bad++; $display("FAIL rmid_clear: got wb=%h err=%b exp wb=0 err=0", g, dmem_err);
      end
      set_nop();
      #1;
      n_cmp++; if (dmem_req_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_valid: got %b exp 0", dmem_req_valid); end
      @(negedge clk);
      #1 rst = 1;
      last_rdata = 32'h0;
      tick();
      sb_q.push_back({1'b0, 1'b0, 5'd0, 32'h0, 32'h0, last_rdata});
      dmem_rsp_valid = 1;
      tick();
      dmem_rsp_valid = 0;
      g = got_wb();
      n_cmp++; if (g !== sb_q[0] || dmem_err !== 1'b0) begin
         n_bad++; $display("FAIL rmid_late: got wb=%h err=%b exp wb=%h err=0", g, dmem_err, sb_q[0]);
      end
      void'(sb_q.pop_front());
   endtask

   task automatic test_back_to_back();
      int st; bit pb, bb; logic v0, we0; wb_t e, g;
      dmem_rdata = 32'hA5A5A5A5;
      last_rdata = 32'hA5A5A5A5;
      sb_q.push_back({1'b1, 1'b1, 5'd3, 32'h1020, 32'h400, last_rdata});
      do_op(0, 1, 1, 5'd3, 32'h1020, 32'h400, 32'h0, 0, 1, 1, st, pb, bb, v0, we0);
      n_cmp++; if (st !== 1) begin n_bad++; $display("FAIL b2b_load_stall: got %0d exp 1", st); end
      e = sb_q.pop_front(); g = got_wb();
      n_cmp++; if (g !== e) begin n_bad++; $display("FAIL b2b_load_wb: got %h exp %h", g, e); end
      sb_q.push_back({1'b0, 1'b0, 5'd0, 32'h1024, 32'h404, last_rdata});
      do_op(1, 0, 0, 5'd0, 32'h1024, 32'h404, 32'h77, 0, 0, 0, st, pb, bb, v0, we0);
      n_cmp++; if (st !== 0) begin n_bad++; $display("FAIL b2b_store_stall: got %0d exp 0", st); end
      e = sb_q.pop_front(); g = got_wb();
      n_cmp++; if (g !== e) begin n_bad++; $display("FAIL b2b_store_wb: got %h exp %h", g, e); end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_store();
      test_load();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
